// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and counter sizing for the sequential multiplier
package mul_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  // A package-level localparam cannot see a module's WIDTH, so counter sizing is a function of it
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: plain WIDTH-bit adder used for the partial-product accumulate
module adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: iterative shift-add multiplier, signed/unsigned, full 2W-bit product
module mul_seq_nbit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mcand, r_mplier, w_abs_a, w_abs_b;
  logic [WIDTH:0]       r_acc, w_addend, w_sum;
  logic [2*WIDTH-1:0]   r_p, w_prod;
  logic                 w_accept, w_last;
  assign w_accept  = in_valid && r_state == IDLE;
  assign w_last    = r_state == BUSY && r_cnt == CNT_W'(WIDTH - 1);
  assign w_abs_a   = (in_signed && A[WIDTH-1]) ? -A : A;
  assign w_abs_b   = (in_signed && B[WIDTH-1]) ? -B : B;
  assign w_addend  = r_mplier[0] ? {1'b0, r_mcand} : '0;
  assign w_prod    = {w_sum, r_mplier[WIDTH-1:1]};
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign P         = r_p;
  adder_nbit #(.WIDTH(WIDTH + 1)) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: accept from IDLE, finish on the last iteration, release on handshake
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = BUSY;
    if (w_last) w_next = DONE;
    if (r_state == DONE && out_ready) w_next = IDLE;
  end
  // datapath: latch magnitudes on accept, then add-and-shift {carry, acc, multiplier} each BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_p      <= '0;
    end else if (w_accept) begin
      r_neg    <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      r_mcand  <= w_abs_a;
      r_mplier <= w_abs_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= {1'b0, w_sum[WIDTH:1]};
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_p <= r_neg ? ~w_prod + 1'b1 : w_prod;
    end
  end
endmodule

// File: tb/tb_mul_seq_nbit.sv
// tb_mul_seq_nbit: directed and randomized checks of mul_seq_nbit at widths 8, 16 and 32
module tb_mul_seq_nbit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic iv8 = 1'b0, is8 = 1'b0, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic ir8, ov8;
  logic [15:0] p8;
  logic iv16 = 1'b0, is16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic ir16, ov16;
  logic [31:0] p16;
  logic iv32 = 1'b0, is32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic ir32, ov32;
  logic [63:0] p32;

  always #5 clk = ~clk;

  mul_seq_nbit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_signed(is8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .P(p8));
  mul_seq_nbit #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_signed(is16), .A(a16), .B(b16),
    .out_valid(ov16), .out_ready(or16), .P(p16));
  mul_seq_nbit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_signed(is32), .A(a32), .B(b32),
    .out_valid(ov32), .out_ready(or32), .P(p32));

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset8 got ir=%b ov=%b P=%h, expected ir=1 ov=0 P=0000", ir8, ov8, p8);
    end
    n_chk++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || p16 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset16 got ir=%b ov=%b P=%h, expected ir=1 ov=0 P=0", ir16, ov16, p16);
    end
    n_chk++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || p32 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset32 got ir=%b ov=%b P=%h, expected ir=1 ov=0 P=0", ir32, ov32, p32);
    end
    rst = 1'b0;
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string nm);
    int lat;
    logic busy_ir;
    busy_ir = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready got in_ready=%b, expected 1", nm, ir8);
    end
    iv8 = 1'b1; is8 = s; a8 = a; b8 = b;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (ov8 !== 1'b1 && lat < 40) begin
      if (ir8 !== 1'b0) busy_ir = 1'b1;
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL %s_latency got %0d cycles, expected 9", nm, lat);
    end
    n_chk++;
    if (p8 !== exp) begin
      n_fail++;
      $display("FAIL %s_product got P=%h, expected %h", nm, p8, exp);
    end
    n_chk++;
    if (busy_ir || ir8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_in_ready_busy got high during operation (now %b), expected 0", nm, ir8);
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    n_chk++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release got ov=%b ir=%b, expected ov=0 ir=1", nm, ov8, ir8);
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                      input string nm);
    int lat;
    @(negedge clk);
    n_chk++;
    if (ir32 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready got in_ready=%b, expected 1", nm, ir32);
    end
    iv32 = 1'b1; is32 = 1'b0; a32 = a; b32 = b; or32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    lat = 1;
    while (ov32 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL %s_latency got %0d cycles, expected 33", nm, lat);
    end
    n_chk++;
    if (p32 !== exp) begin
      n_fail++;
      $display("FAIL %s_product got P=%h, expected %h", nm, p32, exp);
    end
    @(negedge clk);
    or32 = 1'b0;
    n_chk++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_pulse got ov=%b ir=%b, expected ov=0 ir=1", nm, ov32, ir32);
    end
  endtask

  task automatic test_unsigned_max();
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "umax8");
  endtask

  task automatic test_signed_corners();
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "smin_sq");
    op8(1'b1, 8'hFD, 8'h05, 16'hFFF1, "sneg3x5");
    op8(1'b1, 8'h80, 8'h01, 16'hFF80, "smin_x1");
  endtask

  task automatic test_zero_mode();
    op8(1'b1, 8'h00, 8'hA5, 16'h0000, "szero");
    op8(1'b0, 8'h7F, 8'hFF, 16'h7E81, "umode");
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    iv8 = 1'b1; is8 = 1'b0; a8 = 8'd3; b8 = 8'd7; or8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (ov8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (ov8 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_wait got out_valid=%b after %0d cycles, expected 1", ov8, lat);
    end
    iv8 = 1'b1; a8 = 8'h09; b8 = 8'h09;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (ov8 !== 1'b1 || p8 !== 16'h0015 || ir8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got ov=%b P=%h ir=%b, expected ov=1 P=0015 ir=0", i, ov8, p8, ir8);
      end
      @(negedge clk);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    n_chk++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got ov=%b ir=%b, expected ov=0 ir=1", ov8, ir8);
    end
    @(negedge clk);
    n_chk++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle got ov=%b ir=%b, expected ov=0 ir=1", ov8, ir8);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    op32(32'd3, 32'd5, 64'd15, "pre32");
    @(negedge clk);
    iv32 = 1'b1; is32 = 1'b0; a32 = 32'h12345678; b32 = 32'h9ABCDEF0; or32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || p32 !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mid got ir=%b ov=%b P=%h, expected ir=1 ov=0 P=0", ir32, ov32, p32);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov32 !== 1'b0) seen = 1'b1;
    end
    or32 = 1'b0;
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_no_valid got out_valid pulse after reset, expected none");
    end
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "max32");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, t;
    logic [31:0] e;
    logic s, got, done;
    int cyc;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      e = s ? {{16{a[15]}}, a} * {{16{b[15]}}, b} : {16'h0, a} * {16'h0, b};
      t = a * b;
      iv16 = 1'b1; is16 = s; a16 = a; b16 = b;
      @(negedge clk);
      iv16 = 1'b0;
      got = 1'b0; done = 1'b0; cyc = 0;
      while (!done && cyc < 80) begin
        or16 = 1'($urandom_range(0, 1));
        if (ov16 === 1'b1) begin
          if (!got) begin
            got = 1'b1;
            n_chk++;
            if (p16 !== e) begin
              n_fail++;
              $display("FAIL rand%0d_product s=%b A=%h B=%h got P=%h, expected %h", k, s, a, b, p16, e);
            end
            n_chk++;
            if (p16[15:0] !== t) begin
              n_fail++;
              $display("FAIL rand%0d_low A=%h B=%h got %h, expected %h", k, a, b, p16[15:0], t);
            end
          end
          done = or16;
        end
        @(negedge clk);
        cyc++;
      end
      or16 = 1'b0;
      if (!done) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand%0d_timeout got no completed transfer in %0d cycles, expected one", k, cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_zero_mode();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq_nbit.md
# mul_seq_nbit

Parametrised iterative shift-add integer multiplier with a valid/ready handshake. It replaces the fully unrolled combinational multiplier chain with one adder reused over W cycles. It adds a signed/unsigned mode and returns the full 2W-bit product. It sits in the benchmark arithmetic set as the area-minimal multiply for bit-serial PIM mapping, alongside the adder and combinational multiply benchmarks.

## Interface
- `WIDTH`, default 32, operand width in bits; legal range 2..64.
- `clk  input  1  clock`; all logic is on the rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `in_valid  input  1  operands presented`.
- `in_ready  output  1  block can accept an operation`.
- `in_signed  input  1  1 = two's-complement operands, 0 = unsigned`.
- `A  input  WIDTH  multiplicand`.
- `B  input  WIDTH  multiplier`.
- `out_valid  output  1  product available`.
- `out_ready  input  1  consumer takes product`.
- `P  output  2*WIDTH  full product`.

## Operation
- There are three states: IDLE, BUSY and DONE.
- **IDLE**
  - `in_ready`=1.
  - An accept happens when `in_valid`&&`in_ready`. On accept the block:
    - registers the sign flag `neg` = `in_signed` & (A[W-1] ^ B[W-1]);
    - registers the magnitudes |A| and |B|. Absolute value is taken only when `in_signed`. The most-negative value maps to 2^(W-1), which fits unsigned in W bits.
  - It then clears the accumulator, sets the iteration counter to 0 and goes to BUSY.
- **BUSY**
  - Each cycle, if the current multiplier LSB is 1, the registered multiplicand is added into the upper W+1 bits of the accumulator. The {carry, acc, multiplier} register then shifts right by 1.
  - The counter increments each cycle. When the counter reaches WIDTH-1, the final iteration runs in that same cycle. At the end of that cycle the product is negated (two's complement over 2W bits) if `neg`, and the state goes to DONE.
- **DONE**
  - `out_valid`=1 and P holds the result.
  - On `out_valid`&&`out_ready`, the state goes to IDLE.
  - P stays stable while `out_ready`=0. Backpressure is unbounded.
- `in_ready`=0 in BUSY and DONE. There is no overlap of operations; `in_valid` is ignored there.
- **Width rules**
  - Unsigned: P = A*B exactly, range 0..(2^W-1)^2.
  - Signed: P = A*B as a 2W-bit two's-complement value.
  - There is no overflow. The lower W bits always equal the truncated W-bit product.
- **Reset**
  - Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, P=0, counter=0, accumulator=0.
  - Reset during BUSY or DONE abandons the operation. No `out_valid` pulse follows it.
  - Reset has priority over an accept in the same cycle.

## Timing
- The accept edge is t. BUSY occupies cycles t+1..t+W, and `out_valid` is first high in cycle t+W+1.
- Latency is therefore W+1 cycles from accept to `out_valid`.
- With `out_ready` held at 1:
  - `out_valid` is a 1-cycle pulse and `in_ready` returns in cycle t+W+2;
  - sustained throughput is one operation per W+2 cycles.
- No combinational path runs from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`/P.
- P is a register output.

## Structure
- Shared package `mul_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - localparam `CNT_W` = $clog2(WIDTH).
- Sub-module: the existing `adder_nbit`, instantiated at width WIDTH+1 for the partial-product add. The final negation is an increment of the inverted accumulator, inline.
- The counter, the FSM and the shift register all live in `mul_seq_nbit`.

## Test plan
- **Unsigned maximum.** W=8, unsigned, A=0xFF, B=0xFF → P=0xFE01 and `out_valid` exactly 9 cycles after accept; `in_ready` low throughout.
- **Signed corners.** W=8, signed:
  - A=0x80, B=0x80 → P=0x4000;
  - A=0xFD (-3), B=0x05 → P=0xFFF1;
  - A=0x80, B=0x01 → P=0xFF80.
- **Zero and mode check.** W=8:
  - A=0x00, B=0xA5, signed → P=0x0000, `neg` irrelevant;
  - A=0x7F, B=0xFF, unsigned → P=0x7E81.
- **Backpressure.** W=8, 3*7 with `out_ready`=0 for 10 cycles → `out_valid` and P=0x0015 held constant. Then `out_ready`=1 → one transfer, IDLE next cycle. A new `in_valid` during DONE is not accepted.
- **Reset mid-operation.** W=32, `rst` pulsed at BUSY cycle 5 → next cycle all outputs at reset values and no `out_valid`. A following 0xFFFFFFFF*0xFFFFFFFF unsigned op → P=0xFFFFFFFE_00000001.
- **Back-to-back randomized run.** W=16, 1000 random ops with random signed mode and random `in_valid`/`out_ready` gaps, checked against a reference model. Zero mismatches required; lower 16 bits must match the truncated product.
